// File: rtl/motor_drv_pkg.sv
// Shared types and constants for the BLDC gate-drive path: phase states,
// hall-code commutation table and per-phase gate target mapping.
package motor_drv_pkg;

  localparam int         PWM_W         = 11;
  localparam logic [5:0] DEADTIME_DFLT = 6'd32;
  localparam logic [2:0] FAULT_PERIODS = 3'd4;

  typedef enum logic [1:0] {HZ, FWD, REV, BRAKE} phase_state_t;

  typedef struct packed {
    phase_state_t grn;
    phase_state_t ylw;
    phase_state_t blu;
  } phase_vec_t;

  function automatic phase_vec_t pv(input phase_state_t g, input phase_state_t y,
                                    input phase_state_t b);
    phase_vec_t v;
    v.grn = g;
    v.ylw = y;
    v.blu = b;
    return v;
  endfunction

  // hall is {Grn, Ylw, Blu}; 000 and 111 are not legal rotor positions
  function automatic phase_vec_t commutate(input logic [2:0] hall);
    phase_vec_t s;
    s = pv(HZ, HZ, HZ);
    case (hall)
      3'b101:  s = pv(FWD, REV, HZ);
      3'b100:  s = pv(FWD, HZ, REV);
      3'b110:  s = pv(HZ, FWD, REV);
      3'b010:  s = pv(REV, FWD, HZ);
      3'b011:  s = pv(REV, HZ, FWD);
      3'b001:  s = pv(HZ, REV, FWD);
      default: s = pv(HZ, HZ, HZ);
    endcase
    return s;
  endfunction

  // returns {high, low}; never both set
  function automatic logic [1:0] phase_target(input phase_state_t st, input logic p);
    logic [1:0] t;
    t = 2'b00;
    case (st)
      FWD:     t = {p, ~p};
      REV:     t = {~p, p};
      BRAKE:   t = {1'b0, p};
      default: t = 2'b00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/nonoverlap.sv
// Per-phase dead-time inserter: any change of the (high, low) target holds
// both gates low for DEADTIME clocks before the new target is passed through.
module nonoverlap #(
  parameter logic [5:0] DEADTIME = 6'd32
) (
  input  logic clk,
  input  logic rst,
  input  logic target_h,
  input  logic target_l,
  output logic gate_h,
  output logic gate_l
);

  logic [1:0] r_tgt;
  logic [5:0] r_dt;
  logic       w_chg;

  assign w_chg = ({target_h, target_l} != r_tgt);

  // gates are registered, so the gap is the change cycle plus DEADTIME-1 count-down cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tgt  <= 2'b00;
      r_dt   <= 6'd0;
      gate_h <= 1'b0;
      gate_l <= 1'b0;
    end else begin
      r_tgt <= {target_h, target_l};
      if (w_chg) begin
        r_dt   <= DEADTIME - 6'd1;
        gate_h <= 1'b0;
        gate_l <= 1'b0;
      end else if (r_dt != 6'd0) begin
        r_dt   <= r_dt - 6'd1;
        gate_h <= 1'b0;
        gate_l <= 1'b0;
      end else begin
        gate_h <= target_h;
        gate_l <= target_l;
      end
    end
  end

endmodule

// File: rtl/brushless_pwm_drv.sv
// Three-phase BLDC gate driver: 11-bit PWM, hall-based commutation, dead time.
// Optional sticky illegal-hall fault (hall_fault port) under `HALL_FAULT_EN.
module brushless_pwm_drv
  import motor_drv_pkg::*;
#(
  parameter logic [5:0] DEADTIME = DEADTIME_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] drv_mag,
  input  logic        hallGrn,
  input  logic        hallYlw,
  input  logic        hallBlu,
  input  logic        brake_n,
  output logic        highGrn,
  output logic        lowGrn,
  output logic        highYlw,
  output logic        lowYlw,
  output logic        highBlu,
  output logic        lowBlu,
  output logic        PWM_synch
`ifdef HALL_FAULT_EN
  ,
  output logic        hall_fault
`endif
);

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_duty;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_hall;
  logic             w_synch;
  logic             w_p;
  logic             w_unused;
  phase_vec_t       w_state;
  logic [5:0]       w_tgt;
  logic [2:0]       w_gate_h;
  logic [2:0]       w_gate_l;

  assign w_unused  = drv_mag[0];
  assign w_synch   = (r_cnt == '1);
  assign PWM_synch = w_synch;
  assign w_p       = (r_cnt < r_duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_duty  <= '0;
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_hall  <= 3'b000;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
      r_sync1 <= {hallGrn, hallYlw, hallBlu};
      r_sync2 <= r_sync1;
      // duty and rotor position only change on period boundaries
      if (w_synch) begin
        r_duty <= drv_mag[11:1];
        r_hall <= r_sync2;
      end
    end
  end

`ifdef HALL_FAULT_EN
  logic [2:0] r_bad_cnt;
  logic       r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bad_cnt <= 3'd0;
      r_fault   <= 1'b0;
    end else if (w_synch) begin
      if (r_sync2 == 3'b000 || r_sync2 == 3'b111) begin
        if (r_bad_cnt == FAULT_PERIODS - 3'd1) r_fault <= 1'b1;
        else r_bad_cnt <= r_bad_cnt + 3'd1;
      end else if (!r_fault) begin
        r_bad_cnt <= 3'd0;
      end
    end
  end

  assign hall_fault = r_fault;
`endif

  always_comb begin
    w_state = commutate(r_hall);
    if (!brake_n) w_state = pv(BRAKE, BRAKE, BRAKE);
`ifdef HALL_FAULT_EN
    if (r_fault) w_state = pv(HZ, HZ, HZ);
`endif
    w_tgt = {phase_target(w_state.grn, w_p),
             phase_target(w_state.ylw, w_p),
             phase_target(w_state.blu, w_p)};
  end

  // index 2 = green, 1 = yellow, 0 = blue
  for (genvar g = 0; g < 3; g++) begin : g_phase
    nonoverlap #(.DEADTIME(DEADTIME)) u_nonoverlap (
      .clk      (clk),
      .rst      (rst),
      .target_h (w_tgt[2*g+1]),
      .target_l (w_tgt[2*g]),
      .gate_h   (w_gate_h[g]),
      .gate_l   (w_gate_l[g])
    );
  end

  assign highGrn = w_gate_h[2];
  assign lowGrn  = w_gate_l[2];
  assign highYlw = w_gate_h[1];
  assign lowYlw  = w_gate_l[1];
  assign highBlu = w_gate_h[0];
  assign lowBlu  = w_gate_l[0];

endmodule

// File: tb/tb_brushless_pwm_drv.sv
// Scoreboard bench for brushless_pwm_drv: a period-level reference model pushes
// per-cycle expected gates; a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_brushless_pwm_drv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] drv_mag = 12'h000;
  logic        hallGrn = 1'b0, hallYlw = 1'b0, hallBlu = 1'b0;
  logic        brake_n = 1'b1;
  logic        highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_synch;
`ifdef HALL_FAULT_EN
  logic        hall_fault;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  brushless_pwm_drv dut (
    .clk       (clk),
    .rst       (rst),
    .drv_mag   (drv_mag),
    .hallGrn   (hallGrn),
    .hallYlw   (hallYlw),
    .hallBlu   (hallBlu),
    .brake_n   (brake_n),
    .highGrn   (highGrn),
    .lowGrn    (lowGrn),
    .highYlw   (highYlw),
    .lowYlw    (lowYlw),
    .highBlu   (highBlu),
    .lowBlu    (lowBlu),
    .PWM_synch (PWM_synch)
`ifdef HALL_FAULT_EN
    ,
    .hall_fault(hall_fault)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int DT = 32;
  localparam int PERIOD = 2048;

  typedef struct packed {
    logic [5:0] g;
    logic       s;
    logic       f;
  } exp_t;

  exp_t       sb_q[$];
  logic [5:0] hist[$];
  int         m_cnt, m_duty, m_bad;
  logic [2:0] m_hall, hs1, hs2;
  bit         m_fault, m_p, m_stable;
  logic [5:0] m_t, m_e;

  // target vector {hG,lG,hY,lY,hB,lB}; state codes 0=HZ 1=FWD 2=REV 3=BRAKE
  function automatic logic [5:0] targets(input logic [2:0] h, input bit brk,
                                         input bit flt, input bit p);
    int st[3];
    logic [5:0] t;
    case (h)
      3'b101:  st = '{1, 2, 0};
      3'b100:  st = '{1, 0, 2};
      3'b110:  st = '{0, 1, 2};
      3'b010:  st = '{2, 1, 0};
      3'b011:  st = '{2, 0, 1};
      3'b001:  st = '{0, 2, 1};
      default: st = '{0, 0, 0};
    endcase
    if (brk) st = '{3, 3, 3};
    if (flt) st = '{0, 0, 0};
    t = 6'b0;
    for (int k = 0; k < 3; k++) begin
      case (st[k])
        1:       t[5-2*k -: 2] = {p, ~p};
        2:       t[5-2*k -: 2] = {~p, p};
        3:       t[5-2*k -: 2] = {1'b0, p};
        default: t[5-2*k -: 2] = 2'b00;
      endcase
    end
    return t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_duty = 0; m_hall = 3'b000; hs1 = 3'b000; hs2 = 3'b000;
      m_bad = 0; m_fault = 0;
      hist.delete();
      repeat (DT + 1) hist.push_front(6'b0);
    end else begin
      m_p = (m_cnt < m_duty);
      m_t = targets(m_hall, !brake_n, m_fault, m_p);
      hist.push_front(m_t);
      if (hist.size() > DT + 1) void'(hist.pop_back());
      // a gate follows its target only once that target has held for DT+1 samples
      m_e = 6'b0;
      for (int k = 0; k < 3; k++) begin
        m_stable = 1;
        foreach (hist[i]) if (hist[i][5-2*k -: 2] != m_t[5-2*k -: 2]) m_stable = 0;
        if (m_stable) m_e[5-2*k -: 2] = m_t[5-2*k -: 2];
      end
      if (m_cnt == PERIOD - 1) begin
        m_duty = int'(drv_mag) / 2;
        m_hall = hs2;
        if (hs2 == 3'b000 || hs2 == 3'b111) begin
          m_bad++;
          if (m_bad >= 4) m_fault = 1;
        end else if (!m_fault) begin
          m_bad = 0;
        end
      end
      hs2 = hs1;
      hs1 = {hallGrn, hallYlw, hallBlu};
      m_cnt = (m_cnt + 1) % PERIOD;
`ifdef HALL_FAULT_EN
      sb_q.push_back('{g: m_e, s: (m_cnt == PERIOD - 1), f: m_fault});
`else
      sb_q.push_back('{g: m_e, s: (m_cnt == PERIOD - 1), f: 1'b0});
`endif
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      chk("reset_outputs", {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_synch}, 0);
      sb_q.delete();
    end else if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      chk("gates_synch", {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_synch},
          {x.g, x.s});
`ifdef HALL_FAULT_EN
      chk("hall_fault_track", hall_fault, x.f);
`endif
    end
  end

  // ---------------- stimulus ----------------
  int cnt_g[6];

  task automatic set_hall(input logic [2:0] h);
    {hallGrn, hallYlw, hallBlu} = h;
  endtask

  task automatic wait_synch();
    bit ok;
    ok = 0;
    for (int i = 0; i < PERIOD + 50; i++) begin
      @(negedge clk);
      if (PWM_synch) begin
        ok = 1;
        break;
      end
    end
    chk("synch_seen", ok, 1);
  endtask

  // counts gate-high cycles over one period starting right after a PWM_synch cycle
  task automatic measure(input int chg_at, input logic [11:0] d, input logic [2:0] h,
                         input logic b);
    for (int k = 0; k < 6; k++) cnt_g[k] = 0;
    for (int j = 0; j < PERIOD; j++) begin
      @(negedge clk);
      if (j == chg_at) begin
        drv_mag = d;
        set_hall(h);
        brake_n = b;
      end
      cnt_g[0] += int'(highGrn); cnt_g[1] += int'(lowGrn);
      cnt_g[2] += int'(highYlw); cnt_g[3] += int'(lowYlw);
      cnt_g[4] += int'(highBlu); cnt_g[5] += int'(lowBlu);
    end
  endtask

  function automatic int hi_time(input int duty);
    return (duty > DT) ? duty - DT : 0;
  endfunction

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b1;
    drv_mag = 12'h800;
    set_hall(3'b101);
    brake_n = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;

    // half duty, hall 101
    wait_synch();
    measure(-1, 12'h800, 3'b101, 1'b1);
    chk("p1_highGrn", cnt_g[0], hi_time(1024));
    measure(-1, 12'h800, 3'b101, 1'b1);
    chk("p2_highGrn", cnt_g[0], 992);
    chk("p2_lowGrn",  cnt_g[1], 992);
    chk("p2_highYlw", cnt_g[2], 992);
    chk("p2_lowYlw",  cnt_g[3], 992);
    chk("p2_highBlu", cnt_g[4], 0);
    chk("p2_lowBlu",  cnt_g[5], 0);

    // mid-period magnitude change takes effect next period
    measure(300, 12'h400, 3'b101, 1'b1);
    chk("p3_highGrn_unchanged", cnt_g[0], 992);
    chk("p3_lowGrn_unchanged",  cnt_g[1], 992);
    measure(-1, 12'h400, 3'b101, 1'b1);
    chk("p4_highGrn_480", cnt_g[0], hi_time(512));

    // hall 101 -> 100 mid-period
    measure(300, 12'h400, 3'b100, 1'b1);
    chk("p5_highGrn_old_hall", cnt_g[0], 480);
    chk("p5_lowYlw_old_hall",  cnt_g[3], 480);
    measure(-1, 12'h400, 3'b100, 1'b1);
    chk("p6_lowYlw_hz", cnt_g[3], 0);
    chk("p6_lowBlu_pwm", cnt_g[5], 480);

    // duty 0 and full-scale
    measure(100, 12'h000, 3'b101, 1'b1);
    measure(-1, 12'h000, 3'b101, 1'b1);
    measure(-1, 12'h000, 3'b101, 1'b1);
    chk("d0_highGrn_never", cnt_g[0], 0);
    chk("d0_lowGrn_const",  cnt_g[1], PERIOD);
    measure(100, 12'hFFF, 3'b101, 1'b1);
    measure(-1, 12'hFFF, 3'b101, 1'b1);
    measure(-1, 12'hFFF, 3'b101, 1'b1);
    chk("dmax_lowGrn_never", cnt_g[1], 0);
    chk("dmax_highGrn", cnt_g[0], hi_time(2047));

    // brake overrides commutation every cycle
    measure(500, 12'hFFF, 3'b101, 1'b0);
    measure(-1, 12'hFFF, 3'b101, 1'b0);
    chk("brake_highGrn", cnt_g[0], 0);
    chk("brake_lowBlu",  cnt_g[5], hi_time(2047));
    repeat (10) @(negedge clk);
    brake_n = 1'b1;
    repeat (10) @(negedge clk);
    brake_n = 1'b0;
    repeat (100) @(negedge clk);
    brake_n = 1'b1;

    // randomized segments
    for (int s = 0; s < 16; s++) begin
      @(posedge clk);
      #3;
      drv_mag = 12'($urandom);
      if ($urandom_range(0, 5) == 0) drv_mag = ($urandom_range(0, 1) == 1) ? 12'hFFF : 12'h000;
      set_hall(3'($urandom));
      brake_n = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(50, 2500)) @(posedge clk);
    end
    #3 brake_n = 1'b1;

    // asynchronous reset mid-period, then restart from duty 0
    repeat (700) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("midreset_gates_async",
           {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_synch}, 0);
    drv_mag = 12'h600;
    set_hall(3'b011);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    wait_synch();
    measure(-1, 12'h600, 3'b011, 1'b1);
    chk("postreset_highBlu", cnt_g[4], hi_time(768));

`ifdef HALL_FAULT_EN
    set_hall(3'b111);
    repeat (5) wait_synch();
    chk("fault_set", hall_fault, 1);
    set_hall(3'b101);
    repeat (2) wait_synch();
    repeat (40) @(negedge clk);
    chk("fault_sticky", hall_fault, 1);
    chk("fault_gates_off", {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu}, 0);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
